// File: rtl/pooled_act_read_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pooled_act_read_scheduler_pkg
// Brief    : Shared types, constants and helpers for the pooled activation
//            read scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package pooled_act_read_scheduler_pkg;

    localparam int NIBBLES_PER_WORD = 8;
    localparam int DEF_ACT_W        = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_SERVE     = 3'd3,
        S_HOLD      = 3'd4,
        S_RETURN    = 3'd5
    } sched_state_t;

    // Requester count is capped at 8, so a fixed 8-bit one-hot covers every case.
    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pooled_act_read_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : pooled_act_read_scheduler_if
// Brief    : Stage control, stage read port and requester bus bundled together.
// Revision : 1.0 - initial release
// ============================================================================
interface pooled_act_read_scheduler_if
    import pooled_act_read_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int ACT_W   = DEF_ACT_W
);
    logic                      start;
    logic                      stage_start;
    logic                      stage_done;
    logic [ADDR_W-1:0]         stage_addr;
    logic [ACT_W-1:0]          stage_data;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [ACT_W-1:0]          rdata;
    logic                      data_ready;
    logic                      busy;

    modport master (
        input  start, stage_done, stage_data, req, req_addr,
        output stage_start, stage_addr, gnt, rvalid, rdata, data_ready, busy
    );

    modport slave (
        output start, stage_done, stage_data, req, req_addr,
        input  stage_start, stage_addr, gnt, rvalid, rdata, data_ready, busy
    );
endinterface
`default_nettype wire

// File: rtl/pooled_act_read_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pooled_act_read_scheduler_rr_arbiter
// Brief    : Round-robin arbiter; the search starts just after the last grant.
// Revision : 1.0 - initial release
// ============================================================================
module pooled_act_read_scheduler_rr_arbiter
    import pooled_act_read_scheduler_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    input  wire logic [N-1:0]     req_i,
    input  wire logic             advance_i,
    output logic      [N-1:0]     gnt_onehot_o,
    output logic      [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] scan;
    logic             found;

    always_comb begin
        gnt_onehot_o = '0;
        found        = 1'b0;
        scan         = last_q;
        for (int k = 0; k < N; k++) begin
            scan = (scan == IDX_W'(N - 1)) ? '0 : scan + IDX_W'(1);
            if (!found && req_i[scan]) begin
                gnt_onehot_o[scan] = 1'b1;
                found              = 1'b1;
            end
        end
    end

    assign gnt_idx_o = IDX_W'(onehot2idx(8'(gnt_onehot_o)));

    // Pointer starts at N-1 so requester 0 is first after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= IDX_W'(N - 1);
        end else if (advance_i) begin
            last_q <= gnt_idx_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pooled_act_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pooled_act_read_scheduler
// Brief    : Launches one pooling stage, then shares its activation read port
//            among NUM_REQ consumers, one read per READ_LAT+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pooled_act_read_scheduler
    import pooled_act_read_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 32,
    parameter int ACT_W    = DEF_ACT_W,
    parameter int READ_LAT = 1
) (
    input  wire logic                   clk,
    input  wire logic                   resetn,
    pooled_act_read_scheduler_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(READ_LAT + 1);
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(READ_LAT - 1);

    sched_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [ACT_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic               ready_q, ready_d;
    logic               pend_q, pend_d;

    logic [ADDR_W-1:0]  w_req_addr [NUM_REQ];
    logic [NUM_REQ-1:0] w_arb_onehot;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_grant_ok;
    logic               w_grant;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_addr
        assign w_req_addr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    end

    pooled_act_read_scheduler_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk          (clk),
        .resetn       (resetn),
        .req_i        (bus.req),
        .advance_i    (w_grant),
        .gnt_onehot_o (w_arb_onehot),
        .gnt_idx_o    (w_arb_idx)
    );

    // A start (fresh or latched) always beats a grant in the same cycle.
    assign w_grant_ok = !bus.start &&
                        ((state_q == S_SERVE) || (state_q == S_RETURN && !pend_q));
    assign w_grant    = w_grant_ok && (|bus.req);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        gidx_d   = gidx_q;
        rdata_d  = rdata_q;
        rvalid_d = '0;
        ready_d  = ready_q;
        pend_d   = pend_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LAUNCH;
                    ready_d = 1'b0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.stage_done) begin
                    state_d = S_SERVE;
                    ready_d = 1'b1;
                end
            end
            S_SERVE: begin
                if (bus.start) begin
                    state_d = S_LAUNCH;
                    ready_d = 1'b0;
                end else if (w_grant) begin
                    state_d = S_HOLD;
                    addr_d  = w_req_addr[w_arb_idx];
                    gidx_d  = w_arb_idx;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (bus.start) begin
                    pend_d = 1'b1;
                end
                if (cnt_q == C_LAST_CNT) begin
                    state_d = S_RETURN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RETURN: begin
                rdata_d          = bus.stage_data;
                rvalid_d[gidx_q] = 1'b1;
                if (bus.start || pend_q) begin
                    state_d = S_LAUNCH;
                    ready_d = 1'b0;
                    pend_d  = 1'b0;
                end else if (w_grant) begin
                    state_d = S_HOLD;
                    addr_d  = w_req_addr[w_arb_idx];
                    gidx_d  = w_arb_idx;
                    cnt_d   = '0;
                end else begin
                    state_d = S_SERVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            gidx_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
            ready_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            gidx_q   <= gidx_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ready_q  <= ready_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.stage_start = (state_q == S_LAUNCH);
    assign bus.stage_addr  = addr_q;
    assign bus.gnt         = w_grant ? w_arb_onehot : '0;
    assign bus.rvalid      = rvalid_q;
    assign bus.rdata       = rdata_q;
    assign bus.data_ready  = ready_q;
    assign bus.busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT_DONE) ||
                             (state_q == S_HOLD)   || (state_q == S_RETURN);

endmodule
`default_nettype wire

// File: tb/tb_pooled_act_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pooled_act_read_scheduler
// Brief    : Directed scenarios plus random traffic against a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pooled_act_read_scheduler;

    localparam int NUM_REQ  = 2;
    localparam int ADDR_W   = 32;
    localparam int ACT_W    = 4;
    localparam int READ_LAT = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    pooled_act_read_scheduler_if #(
        .NUM_REQ (NUM_REQ), .ADDR_W (ADDR_W), .ACT_W (ACT_W)
    ) bus ();

    pooled_act_read_scheduler #(
        .NUM_REQ (NUM_REQ), .ADDR_W (ADDR_W), .ACT_W (ACT_W), .READ_LAT (READ_LAT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Stage model: registered read pipe of READ_LAT, done pulse after done_delay.
    logic [ACT_W-1:0] pipe [READ_LAT];
    int done_cnt;
    int done_delay = 50;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < READ_LAT; k++) pipe[k] <= '0;
            done_cnt       <= 0;
            bus.stage_done <= 1'b0;
        end else begin
            pipe[0] <= bus.stage_addr[ACT_W-1:0];
            for (int k = 1; k < READ_LAT; k++) pipe[k] <= pipe[k-1];
            bus.stage_done <= 1'b0;
            if (bus.stage_start) begin
                done_cnt <= done_delay;
            end else if (done_cnt == 1) begin
                bus.stage_done <= 1'b1;
                done_cnt       <= 0;
            end else if (done_cnt > 1) begin
                done_cnt <= done_cnt - 1;
            end
        end
    end
    assign bus.stage_data = pipe[READ_LAT-1];

    // Scoreboard and round-robin reference.
    typedef struct {
        int               idx;
        logic [ACT_W-1:0] data;
        int               due;
    } exp_t;

    exp_t             sb [$];
    exp_t             e_pop;
    exp_t             e_push;
    int               glog [$];
    logic [ACT_W-1:0] rlog [$];
    logic [NUM_REQ-1:0] gnt_seen;
    int               starts = 0;
    int               last_g = NUM_REQ - 1;
    int               wait_cnt [NUM_REQ];
    int               g;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            sb.delete();
            last_g   = NUM_REQ - 1;
            gnt_seen = '0;
            for (int j = 0; j < NUM_REQ; j++) wait_cnt[j] = 0;
        end else begin
            gnt_seen = bus.gnt;
            if (bus.stage_start) starts++;
            if (bus.rvalid != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_spurious: rvalid=%b with nothing outstanding", bus.rvalid);
                end else begin
                    e_pop = sb.pop_front();
                    check("rvalid_who", 32'(bus.rvalid), 32'(1) << e_pop.idx);
                    check("rdata", 32'(bus.rdata), 32'(e_pop.data));
                    check("rvalid_latency", cyc, e_pop.due);
                    rlog.push_back(bus.rdata);
                end
            end
            if (bus.gnt != '0) begin
                g = 0;
                for (int j = NUM_REQ - 1; j >= 0; j--) if (bus.gnt[j]) g = j;
                check("gnt_onehot", 32'($onehot(bus.gnt)), 1);
                check("gnt_data_ready", 32'(bus.data_ready), 1);
                check("gnt_has_req", 32'(bus.req[g]), 1);
                check("rr_order", g, rr_pick(bus.req, last_g));
                check("no_starvation", 32'(wait_cnt[g] < NUM_REQ), 1);
                for (int j = 0; j < NUM_REQ; j++) if (j != g && bus.req[j]) wait_cnt[j]++;
                wait_cnt[g] = 0;
                e_push.idx  = g;
                e_push.data = bus.req_addr[g*ADDR_W +: ACT_W];
                e_push.due  = cyc + READ_LAT + 2;
                sb.push_back(e_push);
                glog.push_back(g);
                last_g = g;
            end
            for (int j = 0; j < NUM_REQ; j++) if (!bus.req[j]) wait_cnt[j] = 0;
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done_then_ready(input string name);
        int n = 0;
        while (!bus.stage_done && n < 300) begin
            step(1);
            n++;
        end
        if (!bus.stage_done) begin
            timeout(name);
        end else begin
            check({name, "_ready_low_at_done"}, 32'(bus.data_ready), 0);
            step(1);
            check({name, "_ready_after_done"}, 32'(bus.data_ready), 1);
            check({name, "_busy_after_done"}, 32'(bus.busy), 0);
        end
    endtask

    task automatic wait_gnt(input string name);
        int n = 0;
        #1;
        while (bus.gnt == '0 && n < 30) begin
            step(1);
            #1;
            n++;
        end
        if (bus.gnt == '0) timeout(name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 30) begin
            step(1);
            n++;
        end
        if (bus.busy) timeout(name);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int b;
        int rb;
        int s0;

        bus.start    = 1'b0;
        bus.req      = '0;
        bus.req_addr = '0;
        resetn       = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset values, then a first launch with a 50-cycle stage.
        check("rst_stage_start", 32'(bus.stage_start), 0);
        check("rst_data_ready", 32'(bus.data_ready), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_rdata", 32'(bus.rdata), 0);
        check("rst_stage_addr", bus.stage_addr, 0);
        s0 = starts;
        pulse_start();
        check("t1_stage_start", 32'(bus.stage_start), 1);
        check("t1_busy_launch", 32'(bus.busy), 1);
        check("t1_ready_launch", 32'(bus.data_ready), 0);
        wait_done_then_ready("t1");
        step(2);
        check("t1_one_start_pulse", starts - s0, 1);

        // Two requesters held together alternate.
        b  = glog.size();
        rb = rlog.size();
        bus.req_addr[0*ADDR_W +: ADDR_W] = 32'h13;
        bus.req_addr[1*ADDR_W +: ADDR_W] = 32'h2A;
        bus.req = 2'b11;
        n = 0;
        while (glog.size() < b + 4 && n < 100) begin
            step(1);
            n++;
        end
        bus.req = '0;
        if (glog.size() < b + 4) timeout("t2_grants");
        n = 0;
        while (rlog.size() < rb + 4 && n < 50) begin
            step(1);
            n++;
        end
        if (glog.size() >= b + 4 && rlog.size() >= rb + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("t2_gnt_order", glog[b+k], k % 2);
                check("t2_rdata_seq", 32'(rlog[rb+k]), (k % 2 == 1) ? 32'hA : 32'h3);
            end
        end else begin
            timeout("t2_rvalids");
        end

        // Request raised while the stage is still running.
        wait_idle("t3_idle");
        pulse_start();
        bus.req_addr[1*ADDR_W +: ADDR_W] = 32'h55;
        bus.req = 2'b10;
        n = 0;
        while (!bus.stage_done && n < 300) begin
            check("t3_no_gnt_while_computing", 32'(bus.gnt), 0);
            step(1);
            n++;
        end
        if (!bus.stage_done) timeout("t3_done");
        step(1);
        check("t3_ready", 32'(bus.data_ready), 1);
        check("t3_first_gnt_req1", 32'(bus.gnt), 32'b10);
        step(1);
        bus.req = '0;
        wait_idle("t3_drain");

        // Start during HOLD: in-flight read completes, then relaunch.
        bus.req_addr[0*ADDR_W +: ADDR_W] = 32'h77;
        bus.req = 2'b01;
        wait_gnt("t4_gnt");
        step(1);
        bus.req   = '0;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        s0 = starts;
        n = 0;
        while (bus.rvalid == '0 && n < 20) begin
            check("t4_no_launch_before_rvalid", 32'(bus.stage_start), 0);
            step(1);
            n++;
        end
        check("t4_rvalid", 32'(bus.rvalid), 32'b01);
        check("t4_rdata", 32'(bus.rdata), 32'h7);
        step(2);
        check("t4_relaunch", starts - s0, 1);
        check("t4_ready_low", 32'(bus.data_ready), 0);
        wait_done_then_ready("t4");

        // Reset asserted for one cycle while in RETURN.
        bus.req_addr[0*ADDR_W +: ADDR_W] = 32'h3C;
        bus.req = 2'b01;
        wait_gnt("t5_gnt");
        step(1);
        bus.req = '0;
        step(READ_LAT);
        check("t5_busy_in_return", 32'(bus.busy), 1);
        #2 resetn = 1'b0;
        #1;
        check("t5_async_stage_start", 32'(bus.stage_start), 0);
        check("t5_async_data_ready", 32'(bus.data_ready), 0);
        check("t5_async_busy", 32'(bus.busy), 0);
        check("t5_async_rvalid", 32'(bus.rvalid), 0);
        check("t5_async_rdata", 32'(bus.rdata), 0);
        check("t5_async_stage_addr", bus.stage_addr, 0);
        #9 resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("t5_no_rvalid_after_reset", 32'(bus.rvalid), 0);
            check("t5_idle_after_reset", 32'(bus.busy), 0);
        end
        pulse_start();
        check("t5_restart_pulse", 32'(bus.stage_start), 1);
        wait_done_then_ready("t5");

        // Random traffic with occasional restarts.
        done_delay = 8;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req[i] && gnt_seen[i]) begin
                    if ($urandom_range(1, 0) == 1) bus.req_addr[i*ADDR_W +: ADDR_W] = $urandom;
                    else bus.req[i] = 1'b0;
                end else if (bus.req[i]) begin
                    if ($urandom_range(63, 0) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    bus.req_addr[i*ADDR_W +: ADDR_W] = $urandom;
                    bus.req[i] = 1'b1;
                end
            end
            bus.start = ($urandom_range(299, 0) == 0);
            step(1);
        end
        bus.req   = '0;
        bus.start = 1'b0;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 200) begin
            step(1);
            n++;
        end
        check("t6_scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
